// File: rtl/u712_chip_cycle.sv
// rtl/u712_chip_cycle.sv - CPU chip-bus cycle sequencer aligned to synchronized Amiga C7M slots
module u712_chip_cycle #(
    parameter int CYCLE_SLOTS = 2
) (
    input  logic CLK40B,
    input  logic RESETn,
    input  logic C7M,
    input  logic TSn,
    input  logic RnW,
    input  logic CHIP_REG_SEL,
    input  logic CHIP_RAM_SEL,
    input  logic DBRn,
    input  logic CASUn,
    input  logic CASLn,
    input  logic RAMWEn,
    output logic REG_CYCLE,
    output logic CPU_CYCLE,
    output logic WRITE_CYCLE,
    output logic TACKn
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_SLOT = 3'd1,
        ACCESS    = 3'd2,
        ACK       = 3'd3,
        RECOVER   = 3'd4
    } state_t;

    localparam logic [1:0] SLOTS = 2'(CYCLE_SLOTS);

    state_t     state_q, state_d;
    logic       kind_reg_q, kind_reg_d;
    logic [1:0] cnt_q, cnt_d;
    logic [2:0] c7m_sync_q, c7m_sync_d;
    logic       dma_q, dma_d;
    logic       write_cycle_q, write_cycle_d;
    logic       reg_cycle_q, reg_cycle_d;
    logic       cpu_cycle_q, cpu_cycle_d;
    logic       tack_n_q, tack_n_d;
    logic       c7m_rise;
    logic       dma_active;

    // Direction is not needed for sequencing; the CPU drives the bus itself.
    logic unused_rnw;
    assign unused_rnw = RnW;

    assign dma_active = !CASUn || !CASLn;
    assign c7m_rise   = c7m_sync_q[1] && !c7m_sync_q[2];

    always_comb begin
        state_d    = state_q;
        kind_reg_d = kind_reg_q;
        cnt_d      = cnt_q;
        c7m_sync_d = {c7m_sync_q[1:0], C7M};
        dma_d      = dma_active;

        case (state_q)
            IDLE: begin
                if (!TSn && CHIP_REG_SEL) begin
                    kind_reg_d = 1'b1;
                    state_d    = WAIT_SLOT;
                end else if (!TSn && CHIP_RAM_SEL) begin
                    kind_reg_d = 1'b0;
                    state_d    = WAIT_SLOT;
                end
            end
            WAIT_SLOT: begin
                if (c7m_rise && DBRn && !dma_active) begin
                    state_d = ACCESS;
                    cnt_d   = 2'd0;
                end
            end
            ACCESS: begin
                // Once the slot is won, Agnus activity cannot preempt the access.
                if (c7m_rise) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q + 2'd1 == SLOTS) begin
                        state_d = ACK;
                    end
                end
            end
            ACK:     state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered decodes of the next state so they change with it.
        reg_cycle_d = ((state_d == ACCESS) || (state_d == ACK)) && kind_reg_d;
        cpu_cycle_d = ((state_d == ACCESS) || (state_d == ACK)) && !kind_reg_d;
        tack_n_d    = (state_d != ACK);

        write_cycle_d = dma_active && (write_cycle_q || (!dma_q && !RAMWEn));
    end

    always_ff @(posedge CLK40B or negedge RESETn) begin
        if (!RESETn) begin
            state_q       <= IDLE;
            kind_reg_q    <= 1'b0;
            cnt_q         <= 2'd0;
            c7m_sync_q    <= 3'b000;
            dma_q         <= 1'b0;
            write_cycle_q <= 1'b0;
            reg_cycle_q   <= 1'b0;
            cpu_cycle_q   <= 1'b0;
            tack_n_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            kind_reg_q    <= kind_reg_d;
            cnt_q         <= cnt_d;
            c7m_sync_q    <= c7m_sync_d;
            dma_q         <= dma_d;
            write_cycle_q <= write_cycle_d;
            reg_cycle_q   <= reg_cycle_d;
            cpu_cycle_q   <= cpu_cycle_d;
            tack_n_q      <= tack_n_d;
        end
    end

    assign REG_CYCLE   = reg_cycle_q;
    assign CPU_CYCLE   = cpu_cycle_q;
    assign WRITE_CYCLE = write_cycle_q;
    assign TACKn       = tack_n_q;

endmodule

// File: tb/tb_u712_chip_cycle.sv
// tb/tb_u712_chip_cycle.sv - directed scenario bench for u712_chip_cycle
module tb_u712_chip_cycle;

    logic CLK40B = 1'b0;
    logic RESETn, C7M, TSn, RnW, CHIP_REG_SEL, CHIP_RAM_SEL, DBRn, CASUn, CASLn, RAMWEn;
    logic REG_CYCLE, CPU_CYCLE, WRITE_CYCLE, TACKn;

    int checks = 0;
    int passes = 0;
    int tack_seen = 0;

    u712_chip_cycle #(.CYCLE_SLOTS(2)) dut (
        .CLK40B(CLK40B), .RESETn(RESETn), .C7M(C7M), .TSn(TSn), .RnW(RnW),
        .CHIP_REG_SEL(CHIP_REG_SEL), .CHIP_RAM_SEL(CHIP_RAM_SEL), .DBRn(DBRn),
        .CASUn(CASUn), .CASLn(CASLn), .RAMWEn(RAMWEn),
        .REG_CYCLE(REG_CYCLE), .CPU_CYCLE(CPU_CYCLE), .WRITE_CYCLE(WRITE_CYCLE), .TACKn(TACKn)
    );

    always #5 CLK40B = ~CLK40B;

    always @(negedge CLK40B) if (TACKn === 1'b0) tack_seen++;

    // C7M high; after three CLK40B edges the synchronized rise has been consumed.
    task automatic rise();
        C7M = 1'b1;
        repeat (3) @(negedge CLK40B);
    endtask

    task automatic fall();
        C7M = 1'b0;
        repeat (3) @(negedge CLK40B);
    endtask

    task automatic start(input logic rs, input logic ms);
        TSn = 1'b0; CHIP_REG_SEL = rs; CHIP_RAM_SEL = ms; RnW = 1'b0;
        @(negedge CLK40B);
        TSn = 1'b1; CHIP_REG_SEL = 1'b0; CHIP_RAM_SEL = 1'b0; RnW = 1'b1;
    endtask

    task automatic test_reset();
        RESETn = 1'b0; C7M = 1'b0; TSn = 1'b1; RnW = 1'b1; CHIP_REG_SEL = 1'b0;
        CHIP_RAM_SEL = 1'b0; DBRn = 1'b1; CASUn = 1'b1; CASLn = 1'b1; RAMWEn = 1'b1;
        repeat (3) @(negedge CLK40B);
        checks++;
        if ({REG_CYCLE, CPU_CYCLE, WRITE_CYCLE, TACKn} !== 4'b0001)
            $display("FAIL reset_state got %b exp 0001", {REG_CYCLE, CPU_CYCLE, WRITE_CYCLE, TACKn});
        else passes++;
        RESETn = 1'b1;
        repeat (3) @(negedge CLK40B);
    endtask

    task automatic test_reg_access();
        start(1'b1, 1'b0);
        checks++;
        if ({REG_CYCLE, CPU_CYCLE, TACKn} !== 3'b001)
            $display("FAIL reg_wait got %b exp 001", {REG_CYCLE, CPU_CYCLE, TACKn});
        else passes++;
        rise();
        checks++;
        if ({REG_CYCLE, CPU_CYCLE, TACKn} !== 3'b101)
            $display("FAIL reg_enter got %b exp 101", {REG_CYCLE, CPU_CYCLE, TACKn});
        else passes++;
        fall(); rise();
        checks++;
        if ({REG_CYCLE, TACKn} !== 2'b11)
            $display("FAIL reg_slot1 got %b exp 11", {REG_CYCLE, TACKn});
        else passes++;
        fall(); rise();
        checks++;
        if ({REG_CYCLE, CPU_CYCLE, TACKn} !== 3'b100)
            $display("FAIL reg_ack got %b exp 100", {REG_CYCLE, CPU_CYCLE, TACKn});
        else passes++;
        @(negedge CLK40B);
        checks++;
        if ({REG_CYCLE, CPU_CYCLE, TACKn} !== 3'b001)
            $display("FAIL reg_recover got %b exp 001", {REG_CYCLE, CPU_CYCLE, TACKn});
        else passes++;
        fall();
    endtask

    task automatic test_ram_dbr();
        DBRn = 1'b0;
        start(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            rise();
            checks++;
            if ({REG_CYCLE, CPU_CYCLE, TACKn} !== 3'b001)
                $display("FAIL ram_dbr_hold%0d got %b exp 001", i, {REG_CYCLE, CPU_CYCLE, TACKn});
            else passes++;
            fall();
        end
        DBRn = 1'b1;
        rise();
        checks++;
        if ({REG_CYCLE, CPU_CYCLE, TACKn} !== 3'b011)
            $display("FAIL ram_enter got %b exp 011", {REG_CYCLE, CPU_CYCLE, TACKn});
        else passes++;
        fall(); rise(); fall(); rise();
        checks++;
        if ({CPU_CYCLE, TACKn} !== 2'b10)
            $display("FAIL ram_ack got %b exp 10", {CPU_CYCLE, TACKn});
        else passes++;
        @(negedge CLK40B);
        checks++;
        if ({CPU_CYCLE, TACKn} !== 2'b01)
            $display("FAIL ram_recover got %b exp 01", {CPU_CYCLE, TACKn});
        else passes++;
        fall();
    endtask

    task automatic test_write_cycle();
        CASUn = 1'b0; RAMWEn = 1'b0;
        checks++;
        if (WRITE_CYCLE !== 1'b0) $display("FAIL wr_before got %b exp 0", WRITE_CYCLE);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK40B);
            checks++;
            if (WRITE_CYCLE !== 1'b1) $display("FAIL wr_hold%0d got %b exp 1", i, WRITE_CYCLE);
            else passes++;
        end
        CASUn = 1'b1; RAMWEn = 1'b1;
        @(negedge CLK40B);
        checks++;
        if (WRITE_CYCLE !== 1'b0) $display("FAIL wr_release got %b exp 0", WRITE_CYCLE);
        else passes++;
        CASLn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK40B);
            checks++;
            if (WRITE_CYCLE !== 1'b0) $display("FAIL wr_read%0d got %b exp 0", i, WRITE_CYCLE);
            else passes++;
        end
        CASLn = 1'b1;
        repeat (2) @(negedge CLK40B);
    endtask

    task automatic test_selects();
        int t0;
        #1 t0 = tack_seen;
        @(negedge CLK40B);
        start(1'b0, 1'b0);
        rise();
        checks++;
        if ({REG_CYCLE, CPU_CYCLE, TACKn} !== 3'b001)
            $display("FAIL nosel_outputs got %b exp 001", {REG_CYCLE, CPU_CYCLE, TACKn});
        else passes++;
        fall(); rise(); fall(); rise(); fall();
        #1;
        checks++;
        if (tack_seen !== t0) $display("FAIL nosel_tack got %0d exp %0d", tack_seen, t0);
        else passes++;
        @(negedge CLK40B);
        start(1'b1, 1'b1);
        rise();
        checks++;
        if ({REG_CYCLE, CPU_CYCLE, TACKn} !== 3'b101)
            $display("FAIL both_sel got %b exp 101", {REG_CYCLE, CPU_CYCLE, TACKn});
        else passes++;
        fall(); rise(); fall(); rise();
        checks++;
        if ({REG_CYCLE, CPU_CYCLE, TACKn} !== 3'b100)
            $display("FAIL both_ack got %b exp 100", {REG_CYCLE, CPU_CYCLE, TACKn});
        else passes++;
        fall();
    endtask

    task automatic test_reset_mid();
        int t0;
        start(1'b1, 1'b0);
        rise();
        C7M = 1'b0;
        #1 t0 = tack_seen;
        RESETn = 1'b0;
        #1;
        checks++;
        if ({REG_CYCLE, CPU_CYCLE, TACKn} !== 3'b001)
            $display("FAIL rst_mid got %b exp 001", {REG_CYCLE, CPU_CYCLE, TACKn});
        else passes++;
        repeat (3) @(negedge CLK40B);
        RESETn = 1'b1;
        repeat (3) @(negedge CLK40B);
        #1;
        checks++;
        if (tack_seen !== t0) $display("FAIL rst_no_tack got %0d exp %0d", tack_seen, t0);
        else passes++;
        @(negedge CLK40B);
        start(1'b0, 1'b1);
        rise(); fall(); rise(); fall(); rise();
        checks++;
        if ({REG_CYCLE, CPU_CYCLE, TACKn} !== 3'b010)
            $display("FAIL rst_fresh_ack got %b exp 010", {REG_CYCLE, CPU_CYCLE, TACKn});
        else passes++;
        fall();
    endtask

    task automatic test_dbr_during_access();
        int t0;
        #1 t0 = tack_seen;
        @(negedge CLK40B);
        start(1'b0, 1'b1);
        rise();
        checks++;
        if (CPU_CYCLE !== 1'b1) $display("FAIL dbr_enter got %b exp 1", CPU_CYCLE);
        else passes++;
        DBRn = 1'b0; CASLn = 1'b0;
        fall();
        DBRn = 1'b1;
        rise();
        DBRn = 1'b0; CASLn = 1'b1;
        fall(); rise();
        checks++;
        if ({CPU_CYCLE, TACKn} !== 2'b10)
            $display("FAIL dbr_ack got %b exp 10", {CPU_CYCLE, TACKn});
        else passes++;
        DBRn = 1'b1;
        fall(); fall();
        #1;
        checks++;
        if (tack_seen !== t0 + 1) $display("FAIL dbr_one_tack got %0d exp %0d", tack_seen, t0 + 1);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_reg_access();
        test_ram_dbr();
        test_write_cycle();
        test_selects();
        test_reset_mid();
        test_dbr_during_access();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
